light_sequencer: RTL and testbench

Sequencing controller for the front-panel LED bank. It owns the step timebase and the pattern position, and produces the registered LED drive word from the selected pattern: bounce sweep, rotate, blink or off. Software/top-level logic selects patterns through a valid/ready configuration handshake. Mode changes take effect only on step boundaries, so the display never shows a torn pattern.

---
 rtl/light_pkg.sv | 48 ++++
 rtl/light_prescaler.sv | 28 ++
 rtl/light_sequencer.sv | 117 +++++++++++
 tb/tb_light_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/light_pkg.sv
// Shared types and pattern helpers for the front-panel LED sequencer.
// Pattern functions take the light count as an argument so one package serves any WIDTH up to MAX_WIDTH.
package light_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    localparam int MAX_WIDTH = 64;
    localparam logic [MAX_WIDTH-1:0] ONE_HOT0 = {{(MAX_WIDTH-1){1'b0}}, 1'b1};

    // Number of positions before the index wraps; OFF parks at index 0.
    function automatic int period(mode_t mode, int width);
        case (mode)
            MODE_BOUNCE: period = 2 * width - 2;
            MODE_ROTATE: period = width;
            MODE_BLINK:  period = 2;
            default:     period = 1;
        endcase
    endfunction

    function automatic logic [MAX_WIDTH-1:0] pattern(mode_t mode, int index, int width);
        logic [MAX_WIDTH-1:0] ones;
        ones    = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
        pattern = '0;
        case (mode)
            MODE_BOUNCE: begin
                if (index < width)
                    pattern = ONE_HOT0 << index;
                else
                    pattern = ONE_HOT0 << (2 * width - 2 - index);
            end
            MODE_ROTATE: pattern = ONE_HOT0 << index;
            MODE_BLINK:  pattern = (index == 0) ? ones : '0;
            default:     pattern = '0;
        endcase
    endfunction

endpackage

// File: rtl/light_prescaler.sv
// Step timebase: counts enabled cycles and flags a step once the count reaches div.
// The >= compare makes a live reduction of div fire on the very next enabled cycle.
module light_prescaler #(
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             step
);

    logic [DIV_W-1:0] counter;

    assign step = enable && (counter >= div);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            counter <= '0;
        end else if (step) begin
            counter <= '0;
        end else if (enable) begin
            counter <= counter + DIV_W'(1);
        end
    end

endmodule

// File: rtl/light_sequencer.sv
// LED bank sequencer: owns pattern position and mode, applies requested modes only on step boundaries.
// cfg handshake: a request transfers on any edge where cfg_valid && cfg_ready; cfg_ready is low only while a mode is pending.
module light_sequencer
    import light_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    input  logic             cfg_valid,
    input  logic [1:0]       cfg_mode,
    output logic             cfg_ready,
    output logic [WIDTH-1:0] light,
    output logic             tick,
    output logic             cycle_done,
    output logic [1:0]       fsm_state
);

    localparam int IDX_W = $clog2(2 * WIDTH - 2);

    state_t           state;
    mode_t            mode;
    mode_t            pend_mode;
    logic [IDX_W-1:0] index;
    logic [IDX_W-1:0] index_next;
    logic             step;
    logic             xfer;
    logic             clear;

    function automatic logic [WIDTH-1:0] pat(mode_t m, logic [IDX_W-1:0] i);
        logic [MAX_WIDTH-1:0] full;
        full = pattern(m, int'(i), WIDTH);
        return full[WIDTH-1:0];
    endfunction

    assign cfg_ready = (state != S_PEND);
    assign fsm_state = state;
    assign xfer      = cfg_valid && cfg_ready;
    // Leaving OFF restarts the timebase so the first step is a full interval away.
    assign clear     = xfer && (state == S_OFF);

    always_comb begin
        index_next = index + IDX_W'(1);
        if (int'(index) + 1 >= period(mode, WIDTH))
            index_next = '0;
    end

    light_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .clear  (clear),
        .div    (div),
        .step   (step)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_OFF;
            mode       <= MODE_OFF;
            pend_mode  <= MODE_OFF;
            index      <= '0;
            light      <= '0;
            tick       <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            tick       <= 1'b0;
            cycle_done <= 1'b0;
            case (state)
                S_OFF: begin
                    if (xfer) begin
                        mode  <= mode_t'(cfg_mode);
                        index <= '0;
                        light <= pat(mode_t'(cfg_mode), '0);
                        state <= (mode_t'(cfg_mode) == MODE_OFF) ? S_OFF : S_RUN;
                    end else if (step) begin
                        tick <= 1'b1;
                    end
                end
                S_RUN: begin
                    // A step on the transfer edge still advances the old pattern.
                    if (step) begin
                        index      <= index_next;
                        light      <= pat(mode, index_next);
                        tick       <= 1'b1;
                        cycle_done <= (index_next == '0);
                    end
                    if (xfer) begin
                        pend_mode <= mode_t'(cfg_mode);
                        state     <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (step) begin
                        mode  <= pend_mode;
                        index <= '0;
                        light <= pat(pend_mode, '0);
                        tick  <= 1'b1;
                        state <= (pend_mode == MODE_OFF) ? S_OFF : S_RUN;
                    end
                end
                default: begin
                    state <= S_OFF;
                    mode  <= MODE_OFF;
                    index <= '0;
                    light <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer (WIDTH=4): hand-computed light/tick/cycle_done/ready sequences.
module tb_light_sequencer;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [15:0] div;
    logic        cfg_valid;
    logic [1:0]  cfg_mode;
    logic        cfg_ready;
    logic [3:0]  light;
    logic        tick;
    logic        cycle_done;
    logic [1:0]  fsm_state;

    int vectors;
    int miscompares;

    light_sequencer #(
        .WIDTH (4),
        .DIV_W (16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .div        (div),
        .cfg_valid  (cfg_valid),
        .cfg_mode   (cfg_mode),
        .cfg_ready  (cfg_ready),
        .light      (light),
        .tick       (tick),
        .cycle_done (cycle_done),
        .fsm_state  (fsm_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] exp_light, input logic exp_tick,
                             input logic exp_done);
        check({tag, ".light"}, 32'(light), 32'(exp_light));
        check({tag, ".tick"}, 32'(tick), 32'(exp_tick));
        check({tag, ".cycle_done"}, 32'(cycle_done), 32'(exp_done));
    endtask

    initial begin
        logic [3:0] rot_seq [4];
        logic [3:0] bounce_seq [6];
        vectors     = 0;
        miscompares = 0;
        rot_seq     = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bounce_seq  = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

        // Reset state
        reset = 1'b1; enable = 1'b1; div = 16'd0; cfg_valid = 1'b0; cfg_mode = 2'd0;
        cyc(); cyc();
        check_out("reset", 4'b0000, 1'b0, 1'b0);
        check("reset.ready", 32'(cfg_ready), 32'd1);
        check("reset.state", 32'(fsm_state), 32'd0);

        // BOUNCE at div=0: one cycle from OFF, no tick on apply
        reset = 1'b0; cfg_valid = 1'b1; cfg_mode = 2'd1;
        cyc();
        cfg_valid = 1'b0;
        check_out("bounce.apply", 4'b0001, 1'b0, 1'b0);
        check("bounce.state", 32'(fsm_state), 32'd1);
        for (int i = 0; i < 6; i++) begin
            cyc();
            check_out($sformatf("bounce.step%0d", i), bounce_seq[i], 1'b1, (i == 5));
        end

        // Request OFF from RUN coincident with a step: bounce advances, OFF applied next step
        cfg_valid = 1'b1; cfg_mode = 2'd0;
        cyc();
        cfg_valid = 1'b0;
        check_out("off.coinc", 4'b0010, 1'b1, 1'b0);
        check("off.ready", 32'(cfg_ready), 32'd0);
        cyc();
        check_out("off.apply", 4'b0000, 1'b1, 1'b0);
        check("off.state", 32'(fsm_state), 32'd0);

        // ROTATE at div=3: tick every 4 cycles
        div = 16'd3; cfg_valid = 1'b1; cfg_mode = 2'd2;
        cyc();
        cfg_valid = 1'b0;
        check_out("rot.apply", 4'b0001, 1'b0, 1'b0);
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 3; w++) begin
                cyc();
                check_out($sformatf("rot.wait%0d_%0d", s, w), (s == 0) ? 4'b0001 : rot_seq[s-1], 1'b0, 1'b0);
            end
            cyc();
            check_out($sformatf("rot.step%0d", s), rot_seq[s], 1'b1, (s == 3));
        end

        // enable=0 freezes counter and light
        cyc();
        check_out("freeze.pre", 4'b0001, 1'b0, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check_out($sformatf("freeze%0d", i), 4'b0001, 1'b0, 1'b0);
        end
        enable = 1'b1;
        cyc();
        check_out("resume.c2", 4'b0001, 1'b0, 1'b0);
        cyc();
        check_out("resume.c3", 4'b0001, 1'b0, 1'b0);
        cyc();
        check_out("resume.step", 4'b0010, 1'b1, 1'b0);

        // BOUNCE request on a step edge: rotate advances once, bounce applied one step later
        div = 16'd0; cfg_valid = 1'b1; cfg_mode = 2'd1;
        cyc();
        cfg_valid = 1'b0;
        check_out("coinc.old", 4'b0100, 1'b1, 1'b0);
        check("coinc.ready", 32'(cfg_ready), 32'd0);
        check("coinc.state", 32'(fsm_state), 32'd2);
        cyc();
        check_out("coinc.new", 4'b0001, 1'b1, 1'b0);
        check("coinc.ready_up", 32'(cfg_ready), 32'd1);
        cyc();
        check_out("coinc.b1", 4'b0010, 1'b1, 1'b0);
        cyc();
        check_out("coinc.b2", 4'b0100, 1'b1, 1'b0);

        // In BOUNCE at index 2, request BLINK with div=2
        div = 16'd2; cfg_valid = 1'b1; cfg_mode = 2'd3;
        cyc();
        cfg_valid = 1'b0;
        check_out("blink.xfer", 4'b0100, 1'b0, 1'b0);
        check("blink.ready0", 32'(cfg_ready), 32'd0);
        cyc();
        check_out("blink.wait", 4'b0100, 1'b0, 1'b0);
        check("blink.ready1", 32'(cfg_ready), 32'd0);
        cyc();
        check_out("blink.apply", 4'b1111, 1'b1, 1'b0);
        check("blink.ready2", 32'(cfg_ready), 32'd1);
        cyc();
        check_out("blink.w0", 4'b1111, 1'b0, 1'b0);
        cyc();
        check_out("blink.w1", 4'b1111, 1'b0, 1'b0);
        cyc();
        check_out("blink.off", 4'b0000, 1'b1, 1'b0);

        // Counter at 7 with div=9, then div lowered to 2: step on the next cycle
        div = 16'd9;
        for (int i = 0; i < 7; i++) begin
            cyc();
            check_out($sformatf("divdrop.cnt%0d", i + 1), 4'b0000, 1'b0, 1'b0);
        end
        div = 16'd2;
        cyc();
        check_out("divdrop.step", 4'b1111, 1'b1, 1'b1);
        cyc();
        check_out("divdrop.c1", 4'b1111, 1'b0, 1'b0);
        cyc();
        check_out("divdrop.c2", 4'b1111, 1'b0, 1'b0);
        cyc();
        check_out("divdrop.next", 4'b0000, 1'b1, 1'b0);

        // Reset while a mode is pending discards it
        div = 16'd5; cfg_valid = 1'b1; cfg_mode = 2'd2;
        cyc();
        cfg_valid = 1'b0;
        check("pendrst.state", 32'(fsm_state), 32'd2);
        check("pendrst.ready0", 32'(cfg_ready), 32'd0);
        reset = 1'b1;
        cyc();
        check_out("pendrst.reset", 4'b0000, 1'b0, 1'b0);
        check("pendrst.ready1", 32'(cfg_ready), 32'd1);
        reset = 1'b0; div = 16'd0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_out($sformatf("pendrst.off%0d", i), 4'b0000, 1'b1, 1'b0);
            check($sformatf("pendrst.st%0d", i), 32'(fsm_state), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
